// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-port arbiter.
//   arb_state_e    : arbiter FSM states (IDLE, BURST)
//   DEF_*          : default parameter values for the top level
//   idx_to_onehot  : index (0..7) to one-hot conversion, MAX_REQ bits wide
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_MAX_BURST  = 8;
  localparam int MAX_REQ        = 8;

  function automatic logic [MAX_REQ-1:0] idx_to_onehot(input logic [2:0] idx);
    logic [MAX_REQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req_i   : per-requester request levels
//   last_i  : index of the most recently granted requester
//   pick_o  : first requester with req set, searching from last_i+1 and wrapping
//   valid_o : high when any request is set (pick_o is meaningful)
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_i,
  output logic [IDX_W-1:0]   pick_o,
  output logic               valid_o
);

  logic [IDX_W-1:0] idx;

  // Scan from the farthest offset down to the nearest, so the nearest
  // set request after last_i is the one left in pick_o.
  always_comb begin
    pick_o  = '0;
    valid_o = 1'b0;
    idx     = '0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      idx = IDX_W'((int'(last_i) + off) % NUM_REQ);
      if (req_i[idx]) begin
        pick_o  = idx;
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing the FIFO write port among NUM_REQ producers.
// One requester owns the port for a burst of up to MAX_BURST words; its
// accepted words are forwarded as a registered enqueue strobe plus data.
//
// Handshake: req[k] is the valid of producer k and is held, with its word
// stable on req_data, until a cycle where ack[k] is high; ack[k] is the
// combinational accept (grant & request & ~fifo_full) and a word is taken
// exactly on a rising edge where ack[k] was high.
//
//   clk_write  : write-domain clock, rising edge
//   reset      : asynchronous active-high reset
//   req        : per-requester request level
//   req_data   : packed words, requester k at [k*DATA_WIDTH +: DATA_WIDTH]
//   gnt        : registered one-hot grant, zero when idle
//   ack        : combinational per-word accept
//   fifo_full  : FIFO almost-full (at most one free slot)
//   enqueue    : registered FIFO write strobe
//   data_in    : registered FIFO write data
//   dbg_state  : current FSM state
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MAX_BURST  = DEF_MAX_BURST
) (
  input  logic                          clk_write,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            ack,
  input  logic                          fifo_full,
  output logic                          enqueue,
  output logic [DATA_WIDTH-1:0]         data_in,
  output arb_state_e                    dbg_state
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  arb_state_e              state_q, state_d;
  logic [IDX_W-1:0]        own_q, own_d;
  logic [IDX_W-1:0]        last_q, last_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [NUM_REQ-1:0]      gnt_q, gnt_d;
  logic                    enq_q, enq_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;

  logic [IDX_W-1:0]        pick_idx;
  logic                    pick_valid;
  logic [NUM_REQ-1:0]      pick_oh;
  logic                    accept;
  logic [DATA_WIDTH-1:0]   own_data;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req_i   (req),
    .last_i  (last_q),
    .pick_o  (pick_idx),
    .valid_o (pick_valid)
  );

  assign pick_oh  = NUM_REQ'(idx_to_onehot(3'(pick_idx)));
  // gnt_q is only non-zero in BURST, so ack is zero when idle.
  assign ack      = gnt_q & req & {NUM_REQ{~fifo_full}};
  assign accept   = ack[own_q];
  assign own_data = req_data[int'(own_q)*DATA_WIDTH +: DATA_WIDTH];

  always_comb begin
    state_d = state_q;
    own_d   = own_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    enq_d   = 1'b0;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (pick_valid) begin
          state_d = BURST;
          own_d   = pick_idx;
          last_d  = pick_idx;
          cnt_d   = '0;
          gnt_d   = pick_oh;
        end
      end
      BURST: begin
        if (accept) begin
          enq_d  = 1'b1;
          data_d = own_data;
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(MAX_BURST - 1)) begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end else if (!req[own_q]) begin
          // Owner withdrew; a full FIFO with req still high is a stall instead.
          state_d = IDLE;
          gnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_write or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      own_q   <= '0;
      last_q  <= IDX_W'(NUM_REQ - 1);
      cnt_q   <= '0;
      gnt_q   <= '0;
      enq_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      enq_q   <= enq_d;
      data_q  <= data_d;
    end
  end

  assign gnt       = gnt_q;
  assign enqueue   = enq_q;
  assign data_in   = data_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
module tb_fifo_write_arbiter;
  import fifo_arb_pkg::*;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int MB = 8;
  localparam int FIFO_DEPTH = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [NR-1:0]    req = '0;
  logic [NR*DW-1:0] req_data = '0;
  logic             fifo_full = 1'b0;
  logic [NR-1:0]    gnt, ack;
  logic             enqueue;
  logic [DW-1:0]    data_in;
  arb_state_e       dbg_state;

  fifo_write_arbiter #(
    .NUM_REQ    (NR),
    .DATA_WIDTH (DW),
    .MAX_BURST  (MB)
  ) dut (
    .clk_write (clk),
    .reset     (reset),
    .req       (req),
    .req_data  (req_data),
    .gnt       (gnt),
    .ack       (ack),
    .fifo_full (fifo_full),
    .enqueue   (enqueue),
    .data_in   (data_in),
    .dbg_state (dbg_state)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model + producers + scoreboard ----------------
  int         m_owner;     // -1 when nobody holds the port
  int         m_cnt;
  int         m_last;
  logic       m_enq;
  logic [7:0] m_data;

  logic [7:0] pq[NR][$];   // words each producer still has to send
  bit         pres[NR];
  bit         acked_last[NR];
  bit         want[NR];
  bit         rnd_gap;
  bit         fill_mode;
  int         fifo_cnt;
  logic [7:0] fifo_mem[$];
  logic [DW-1:0] exp_q[$];
  logic [3:0] gnt_log[$];
  logic [3:0] prev_gnt;
  int         enq_count;

  task automatic model_reset();
    m_owner = -1; m_cnt = 0; m_last = NR - 1; m_enq = 1'b0; m_data = '0;
    for (int k = 0; k < NR; k++) begin
      pres[k] = 0; acked_last[k] = 0; want[k] = 0; pq[k].delete();
    end
    exp_q.delete(); gnt_log.delete(); fifo_mem.delete();
    prev_gnt = '0; enq_count = 0; fifo_cnt = 0; rnd_gap = 0; fill_mode = 0;
  endtask

  task automatic reset_dut();
    @(posedge clk); #1;
    reset = 1'b1; req = '0; req_data = '0; fifo_full = 1'b0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    @(posedge clk); #1;
    model_reset();
  endtask

  // One clock cycle: called at posedge+1, returns at the next posedge+1.
  task automatic tick(input bit full_in);
    logic       f;
    logic [3:0] pa;
    bit         found;
    f = fill_mode ? ((FIFO_DEPTH - fifo_cnt) <= 1) : full_in;
    for (int k = 0; k < NR; k++) begin
      // A presented word stays presented until it has been accepted.
      if (!pres[k] || acked_last[k])
        pres[k] = want[k] && (pq[k].size() > 0) && (!rnd_gap || $urandom_range(3) != 0);
      req[k] = pres[k];
      req_data[k*DW +: DW] = (pq[k].size() > 0) ? pq[k][0] : 8'h00;
    end
    fifo_full = f;
    #1;
    pa = (m_owner >= 0 && req[m_owner] && !f) ? 4'(1 << m_owner) : 4'h0;
    check("gnt",     gnt,     (m_owner >= 0) ? (1 << m_owner) : 0);
    check("ack",     ack,     pa);
    check("enqueue", enqueue, m_enq);
    check("data_in", data_in, m_data);
    check("state",   int'(dbg_state), (m_owner >= 0) ? 1 : 0);
    if (enqueue) begin
      enq_count++;
      if (exp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL enq_extra: got enqueue data 0x%0h expected no enqueue at %0t", data_in, $time);
      end else begin
        check("enq_data", data_in, exp_q.pop_front());
      end
      if (fill_mode) begin
        check("fifo_overflow", (fifo_cnt < FIFO_DEPTH) ? 1 : 0, 1);
        fifo_mem.push_back(data_in);
        fifo_cnt++;
      end
    end
    if (gnt != 0 && prev_gnt == 0) gnt_log.push_back(gnt);
    prev_gnt = gnt;
    // advance the model across the coming edge
    for (int k = 0; k < NR; k++) acked_last[k] = 0;
    if (m_owner < 0) begin
      m_enq = 1'b0;
      found = 0;
      for (int i = 1; i <= NR; i++) begin
        if (!found && req[(m_last + i) % NR]) begin
          found = 1;
          m_owner = (m_last + i) % NR;
          m_last = m_owner;
          m_cnt = 0;
        end
      end
    end else if (pa != 0) begin
      m_enq = 1'b1;
      m_data = pq[m_owner].pop_front();
      exp_q.push_back(m_data);
      acked_last[m_owner] = 1;
      m_cnt++;
      if (m_cnt == MB) m_owner = -1;
    end else begin
      m_enq = 1'b0;
      if (!req[m_owner]) m_owner = -1;
    end
    @(posedge clk); #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [3:0] req;
    logic [7:0] word;
    logic       full;
    logic [3:0] gnt;
    logic [3:0] ack;
    logic       enq;
    logic [7:0] data;
  } vec_t;

  vec_t vt[10];

  initial begin
    // requester 2 sends AA, CC and drops; then requester 0 stalls one cycle
    vt[0] = '{4'b0100, 8'hAA, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h00};
    vt[1] = '{4'b0100, 8'hAA, 1'b0, 4'b0100, 4'b0100, 1'b0, 8'h00};
    vt[2] = '{4'b0100, 8'hCC, 1'b0, 4'b0100, 4'b0100, 1'b1, 8'hAA};
    vt[3] = '{4'b0000, 8'h00, 1'b0, 4'b0100, 4'b0000, 1'b1, 8'hCC};
    vt[4] = '{4'b0000, 8'h00, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'hCC};
    vt[5] = '{4'b0001, 8'h11, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'hCC};
    vt[6] = '{4'b0001, 8'h11, 1'b1, 4'b0001, 4'b0000, 1'b0, 8'hCC};
    vt[7] = '{4'b0001, 8'h11, 1'b0, 4'b0001, 4'b0001, 1'b0, 8'hCC};
    vt[8] = '{4'b0000, 8'h00, 1'b0, 4'b0001, 4'b0000, 1'b1, 8'h11};
    vt[9] = '{4'b0000, 8'h00, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h11};

    model_reset();
    reset_dut();

    // reset state, with every requester asking (grant must still be zero)
    req = 4'hF; #1;
    check("rst_gnt", gnt, 0);
    check("rst_ack", ack, 0);
    check("rst_enqueue", enqueue, 0);
    check("rst_data_in", data_in, 0);
    check("rst_state", int'(dbg_state), int'(IDLE));
    req = '0;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      req = vt[i].req; req_data = {NR{vt[i].word}}; fifo_full = vt[i].full;
      #1;
      check($sformatf("vec%0d_gnt", i), gnt, vt[i].gnt);
      check($sformatf("vec%0d_ack", i), ack, vt[i].ack);
      check($sformatf("vec%0d_enq", i), enqueue, vt[i].enq);
      check($sformatf("vec%0d_data", i), data_in, vt[i].data);
      @(posedge clk); #1;
    end

    // all four requesting continuously: grants 0,1,2,3,0
    reset_dut();
    for (int k = 0; k < NR; k++) begin
      want[k] = 1;
      for (int i = 0; i < 20; i++) pq[k].push_back(8'((k << 5) | i));
    end
    repeat (45) tick(1'b0);
    check("rr_order0", gnt_log.size() > 0 ? gnt_log[0] : 0, 4'b0001);
    check("rr_order1", gnt_log.size() > 1 ? gnt_log[1] : 0, 4'b0010);
    check("rr_order2", gnt_log.size() > 2 ? gnt_log[2] : 0, 4'b0100);
    check("rr_order3", gnt_log.size() > 3 ? gnt_log[3] : 0, 4'b1000);
    check("rr_order4", gnt_log.size() > 4 ? gnt_log[4] : 0, 4'b0001);

    // back-pressure: fifo_full for 5 cycles in the middle of requester 1's burst
    reset_dut();
    want[1] = 1;
    for (int i = 0; i < 12; i++) pq[1].push_back(8'h40 + 8'(i));
    for (int c = 0; c < 30; c++) tick(c >= 4 && c < 9);
    check("bp_enq_count", enq_count, 12);
    check("bp_pending", exp_q.size(), 0);
    check("bp_left", pq[1].size(), 0);

    // fill a 32-deep FIFO whose almost-full drives fifo_full
    reset_dut();
    fill_mode = 1;
    want[0] = 1;
    for (int i = 0; i < 34; i++) pq[0].push_back(8'(i));
    repeat (70) tick(1'b0);
    check("fill_enq_count", enq_count, FIFO_DEPTH);
    check("fill_pending", exp_q.size(), 0);
    for (int i = 0; i < FIFO_DEPTH; i++)
      check($sformatf("fill_rd%0d", i), (fifo_mem.size() > i) ? fifo_mem[i] : 8'hFF, i);
    fill_mode = 0;

    // reset while requester 0 presents its fourth word
    reset_dut();
    want[0] = 1;
    for (int i = 0; i < 10; i++) pq[0].push_back(8'h60 + 8'(i));
    repeat (4) tick(1'b0);
    req = 4'b0001; req_data[0 +: DW] = pq[0][0];
    #1 reset = 1'b1;
    #1;
    check("midrst_gnt", gnt, 0);
    check("midrst_enqueue", enqueue, 0);
    check("midrst_data_in", data_in, 0);
    check("midrst_ack", ack, 0);
    check("midrst_state", int'(dbg_state), int'(IDLE));
    req = '0;
    @(posedge clk);
    #3 reset = 1'b0;
    @(posedge clk); #1;
    model_reset();
    for (int k = 0; k < NR; k++) begin
      want[k] = 1;
      for (int i = 0; i < 4; i++) pq[k].push_back(8'h80 + 8'((k << 4) | i));
    end
    repeat (3) tick(1'b0);
    check("midrst_first_gnt", gnt_log.size() > 0 ? gnt_log[0] : 0, 4'b0001);

    // requester 3 drops after two words; requester 0 gets the next grant
    reset_dut();
    want[3] = 1;
    pq[3].push_back(8'hD0); pq[3].push_back(8'hD1);
    for (int i = 0; i < 4; i++) pq[0].push_back(8'hE0 + 8'(i));
    repeat (2) tick(1'b0);
    want[0] = 1;
    repeat (12) tick(1'b0);
    check("drop_gnt_first", gnt_log.size() > 0 ? gnt_log[0] : 0, 4'b1000);
    check("drop_gnt_next", gnt_log.size() > 1 ? gnt_log[1] : 0, 4'b0001);
    check("drop_enq_count", enq_count, 6);

    // randomized traffic with random back-pressure and request gaps
    reset_dut();
    rnd_gap = 1;
    for (int k = 0; k < NR; k++) want[k] = 1;
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < NR; k++)
        if (pq[k].size() == 0)
          repeat ($urandom_range(12, 1)) pq[k].push_back(8'($urandom_range(255)));
      tick($urandom_range(99) < 25);
    end
    for (int k = 0; k < NR; k++) want[k] = 0;
    repeat (80) tick(1'b0);
    check("rand_pending", exp_q.size(), 0);
    check("rand_idle", int'(dbg_state), int'(IDLE));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
